// File: rtl/iob_ram_sp_ctrl.sv
// Valid/ready request front end for the single-port RAM iob_ram_sp, with a 2-entry read response buffer.
// Optional post-reset zero-fill of the RAM is compiled in with `define IOB_RAM_SP_CTRL_CLEAR_EN.
module iob_ram_sp_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_d_o,
  input  logic [DATA_W-1:0] ram_d_i,
  output logic              busy_o
);

  logic              busy;
  logic              accept;
  logic              credit_ok;
  logic [1:0]        used;
  logic              bypass;
  logic              push;
  logic              pop;

  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];

`ifdef IOB_RAM_SP_CTRL_CLEAR_EN
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

  always_comb begin
    busy_d     = busy_q;
    clr_addr_d = clr_addr_q;
    if (busy_q) begin
      clr_addr_d = clr_addr_q + 1'b1;
      if (clr_addr_q == '1) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      busy_q     <= 1'b1;
      clr_addr_q <= '0;
    end else begin
      busy_q     <= busy_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign busy = busy_q;

  always_comb begin
    ram_en_o   = accept;
    ram_we_o   = req_we_i;
    ram_addr_o = req_addr_i;
    ram_d_o    = req_wdata_i;
    if (busy) begin
      ram_en_o   = 1'b1;
      ram_we_o   = 1'b1;
      ram_addr_o = clr_addr_q;
      ram_d_o    = '0;
    end
  end
`else
  assign busy = 1'b0;

  always_comb begin
    ram_en_o   = accept;
    ram_we_o   = req_we_i;
    ram_addr_o = req_addr_i;
    ram_d_o    = req_wdata_i;
  end
`endif

  // Credit counts the word in the RAM pipe plus buffered words; a same-cycle pop does not free it.
  assign used        = count_q + {1'b0, inflight_q};
  assign credit_ok   = !used[1];
  assign req_ready_o = !busy && (req_we_i || credit_ok);
  assign accept      = req_valid_i && req_ready_o;
  assign busy_o      = busy;

  assign bypass      = inflight_q && (count_q == 2'd0);
  assign rsp_valid_o = bypass || (count_q != 2'd0);
  assign rsp_rdata_o = bypass ? ram_d_i : buf_q[rd_ptr_q];
  assign pop         = (count_q != 2'd0) && rsp_ready_i;
  assign push        = inflight_q && !(bypass && rsp_ready_i);

  always_comb begin
    inflight_d = accept && !req_we_i;
    buf_d      = buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      buf_d[wr_ptr_q] = ram_d_i;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (pop) rd_ptr_d = !rd_ptr_q;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) buf_q[i] <= '0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      buf_q      <= buf_d;
    end
  end

endmodule

// File: tb/tb_iob_ram_sp_ctrl.sv
// Bench for iob_ram_sp_ctrl: behavioural RAM, shadow memory and expected-response queue as reference.
// Builds with or without `define IOB_RAM_SP_CTRL_CLEAR_EN.
module tb_iob_ram_sp_ctrl;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          arst_i;
  logic          req_valid_i, req_we_i, rsp_ready_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic          req_ready_o, rsp_valid_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [DW-1:0] ram_d_o, ram_d_i;
  logic          busy_o;

  always #5 clk = ~clk;

  iob_ram_sp_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i(clk), .arst_i(arst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_d_o(ram_d_o), .ram_d_i(ram_d_i), .busy_o(busy_o)
  );

  // Attached single-port RAM: registered read, write-first not needed since one op per cycle.
  logic [DW-1:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) ram_mem[ram_addr_o] <= ram_d_o;
      else          ram_d_i <= ram_mem[ram_addr_o];
    end
  end

  // Reference model
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] expq [$];
  int            clr_cnt;
  int            busy_seen;
  logic          last_acc;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    arst_i      = 1'b1;
    #1;
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_rdata", rsp_rdata_o, 0);
`ifdef IOB_RAM_SP_CTRL_CLEAR_EN
    chk("rst_busy", busy_o, 1);
    chk("rst_req_ready", req_ready_o, 0);
`else
    chk("rst_busy", busy_o, 0);
    chk("rst_req_ready", req_ready_o, 1);
`endif
    @(posedge clk);
    #1;
    arst_i = 1'b0;
    expq.delete();
`ifdef IOB_RAM_SP_CTRL_CLEAR_EN
    shadow[0] = '0;
    clr_cnt   = 0;
`else
    clr_cnt   = DEPTH;
`endif
  endtask

  // One cycle: drive, check at negedge against the model, advance model at posedge.
  task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] wd, input logic rr);
    logic busy_e, rdy_e, acc, hs;
    req_valid_i = v;
    req_we_i    = we;
    req_addr_i  = a;
    req_wdata_i = wd;
    rsp_ready_i = rr;
    @(negedge clk);
    busy_e = (clr_cnt < DEPTH);
    rdy_e  = !busy_e && (we || expq.size() < 2);
    if (busy_o) busy_seen++;
    chk("busy", busy_o, busy_e);
    chk("req_ready", req_ready_o, rdy_e);
    chk("rsp_valid", rsp_valid_o, expq.size() != 0);
    if (expq.size() != 0) chk("rsp_rdata", rsp_rdata_o, expq[0]);
    if (busy_e) begin
      chk("clr_en", ram_en_o, 1);
      chk("clr_we", ram_we_o, 1);
      chk("clr_addr", ram_addr_o, clr_cnt);
      chk("clr_d", ram_d_o, 0);
    end else begin
      chk("ram_en", ram_en_o, v && rdy_e);
      chk("ram_we", ram_we_o, we);
      chk("ram_addr", ram_addr_o, a);
      chk("ram_d", ram_d_o, wd);
    end
    acc = v && rdy_e;
    hs  = (expq.size() != 0) && rr;
    @(posedge clk);
    if (busy_e) begin
      shadow[clr_cnt] = '0;
      clr_cnt++;
    end
    if (hs) void'(expq.pop_front());
    if (acc && we)  shadow[a] = wd;
    if (acc && !we) expq.push_back(shadow[a]);
    last_acc = acc;
    #1;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, rr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    arst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0; rsp_ready_i = 1'b0;
    busy_seen = 0; last_acc = 1'b0; clr_cnt = 0;
    #2;
    do_reset();

`ifdef IOB_RAM_SP_CTRL_CLEAR_EN
    idle(DEPTH + 2, 1'b1);
    chk("busy_cycles", busy_seen, DEPTH);
    step(1'b1, 1'b0, 4'd7, '0, 1'b1);
    chk("clr_read7_valid", rsp_valid_o, 1);
    chk("clr_read7_data", rsp_rdata_o, 0);
    idle(1, 1'b1);
    // Reset at clear address 9 must restart the sweep from 0.
    do_reset();
    idle(9, 1'b0);
    chk("clr_at9", ram_addr_o, 9);
    do_reset();
    busy_seen = 0;
    idle(DEPTH + 1, 1'b0);
    chk("busy_cycles_restart", busy_seen, DEPTH);
`else
    step(1'b1, 1'b1, 4'd3, 32'h1234_5678, 1'b1);
    chk("first_cycle_accept", last_acc, 1);
    chk("busy_const0", busy_o, 0);
`endif

    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, i[AW-1:0], $urandom, 1'b1);

    // Write then read back (0x010 folds onto address 0 at this width)
    step(1'b1, 1'b1, 4'h0, 32'hA5A5_0001, 1'b1);
    step(1'b1, 1'b0, 4'h0, '0, 1'b1);
    chk("wr_rd_valid", rsp_valid_o, 1);
    chk("wr_rd_data", rsp_rdata_o, 32'hA5A5_0001);
    idle(1, 1'b1);

    for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, i[AW-1:0], '0, 1'b1);
    idle(2, 1'b1);

    // Backpressure: two reads accepted, third refused, write still accepted
    step(1'b1, 1'b0, 4'd5, '0, 1'b0);
    step(1'b1, 1'b0, 4'd6, '0, 1'b0);
    step(1'b1, 1'b0, 4'd7, '0, 1'b0);
    chk("bp_read_refused", last_acc, 0);
    step(1'b1, 1'b1, 4'd9, $urandom, 1'b0);
    chk("bp_write_accepted", last_acc, 1);
    step(1'b1, 1'b0, 4'd8, '0, 1'b0);
    chk("bp_read_refused2", last_acc, 0);
    step(1'b1, 1'b0, 4'd7, '0, 1'b1);
    chk("bp_no_credit_on_pop", last_acc, 0);
    step(1'b1, 1'b0, 4'd7, '0, 1'b1);
    chk("bp_read_resumes", last_acc, 1);
    idle(3, 1'b1);

    // Reset while two responses are buffered
    step(1'b1, 1'b0, 4'd1, '0, 1'b0);
    step(1'b1, 1'b0, 4'd2, '0, 1'b0);
    idle(1, 1'b0);
    do_reset();
    idle(DEPTH + 2, 1'b1);
    step(1'b1, 1'b1, 4'd3, 32'hCAFE_0003, 1'b1);
    step(1'b1, 1'b0, 4'd3, '0, 1'b1);
    chk("post_rst_data", rsp_rdata_o, 32'hCAFE_0003);
    idle(1, 1'b1);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
           AW'($urandom_range(0, DEPTH - 1)), $urandom, $urandom_range(0, 9) < 6);
    idle(4, 1'b1);
    chk("drained", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
